// File: rtl/fpu_pkg.sv
// Shared opcode, FSM-state and strobe-index constants for the FPU front-end sequencer.
package fpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_INV  = 4'd4;
    localparam logic [3:0] OP_ABS  = 4'd5;
    localparam logic [3:0] OP_COM  = 4'd6;
    localparam logic [3:0] OP_BLT  = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_BGT  = 4'd9;
    localparam logic [3:0] OP_LAST = 4'd9;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int STB_ADD = 0;
    localparam int STB_SUB = 1;
    localparam int STB_MUL = 2;
    localparam int STB_DIV = 3;
    localparam int STB_INV = 4;
    localparam int STB_ABS = 5;
    localparam int STB_COM = 6;
    localparam int STB_BLT = 7;
    localparam int STB_BEQ = 8;
    localparam int STB_BGT = 9;
    localparam int NUM_STB = 10;

    function automatic logic is_branch_op(input logic [3:0] op);
        return (op == OP_BLT) || (op == OP_BEQ) || (op == OP_BGT);
    endfunction

endpackage

// File: rtl/fpu_op_sequencer_if.sv
// Request, ALU and response signals of the sequencer; slave = sequencer view, master = core/ALU view.
interface fpu_op_sequencer_if #(parameter int WIDTH = 32);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_opcode;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [WIDTH-1:0] alu_op1;
    logic [WIDTH-1:0] alu_op2;
    logic             alu_add, alu_sub, alu_mul, alu_div, alu_inv;
    logic             alu_abs, alu_com, alu_blt, alu_beq, alu_bgt;
    logic [WIDTH-1:0] alu_result;
    logic             alu_com_result;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_flag;
    logic             resp_err;

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, resp_ready, alu_result, alu_com_result,
        output req_ready, alu_op1, alu_op2,
        output alu_add, alu_sub, alu_mul, alu_div, alu_inv,
        output alu_abs, alu_com, alu_blt, alu_beq, alu_bgt,
        output resp_valid, resp_data, resp_flag, resp_err
    );

    modport master (
        output req_valid, req_opcode, req_a, req_b, resp_ready, alu_result, alu_com_result,
        input  req_ready, alu_op1, alu_op2,
        input  alu_add, alu_sub, alu_mul, alu_div, alu_inv,
        input  alu_abs, alu_com, alu_blt, alu_beq, alu_bgt,
        input  resp_valid, resp_data, resp_flag, resp_err
    );
endinterface

// File: rtl/fpu_op_decode.sv
// Combinational opcode decode: ALU strobe vector, execute latency minus one, branch and illegal flags.
module fpu_op_decode
    import fpu_pkg::*;
#(
    parameter int LAT_FAST = 1,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 8,
    parameter int CNT_W    = 3
) (
    input  logic [3:0]         i_opcode,
    output logic [NUM_STB-1:0] o_strobe,
    output logic [CNT_W-1:0]   o_lat_m1,
    output logic               o_branch,
    output logic               o_illegal
);

    always_comb begin
        o_strobe  = '0;
        o_lat_m1  = CNT_W'(LAT_FAST - 1);
        o_branch  = is_branch_op(i_opcode);
        o_illegal = 1'b0;
        case (i_opcode)
            OP_ADD: o_strobe[STB_ADD] = 1'b1;
            OP_SUB: o_strobe[STB_SUB] = 1'b1;
            OP_MUL: begin
                o_strobe[STB_MUL] = 1'b1;
                o_lat_m1          = CNT_W'(LAT_MUL - 1);
            end
            OP_DIV: begin
                o_strobe[STB_DIV] = 1'b1;
                o_lat_m1          = CNT_W'(LAT_DIV - 1);
            end
            OP_INV: o_strobe[STB_INV] = 1'b1;
            OP_ABS: o_strobe[STB_ABS] = 1'b1;
            OP_COM: o_strobe[STB_COM] = 1'b1;
            // Branch compares need the comparator strobe alongside the branch select.
            OP_BLT: begin
                o_strobe[STB_COM] = 1'b1;
                o_strobe[STB_BLT] = 1'b1;
            end
            OP_BEQ: begin
                o_strobe[STB_COM] = 1'b1;
                o_strobe[STB_BEQ] = 1'b1;
            end
            OP_BGT: begin
                o_strobe[STB_COM] = 1'b1;
                o_strobe[STB_BGT] = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// FPU front-end: accepts one op, holds ALU strobes/operands for the op latency, returns the captured result.
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int LAT_FAST = 1,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 8
) (
    input logic                clk,
    input logic                rst_n,
    fpu_op_sequencer_if.slave  bus
);

    localparam int LAT_MAX = (LAT_FAST > LAT_MUL) ? ((LAT_FAST > LAT_DIV) ? LAT_FAST : LAT_DIV)
                                                  : ((LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV);
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_STB-1:0] r_strobe;
    logic [WIDTH-1:0]   r_op1;
    logic [WIDTH-1:0]   r_op2;
    logic               r_branch;
    logic               r_resp_valid;
    logic [WIDTH-1:0]   r_resp_data;
    logic               r_resp_flag;
    logic               r_resp_err;

    logic [NUM_STB-1:0] w_strobe;
    logic [CNT_W-1:0]   w_lat_m1;
    logic               w_branch;
    logic               w_illegal;

    fpu_op_decode #(
        .LAT_FAST (LAT_FAST),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV),
        .CNT_W    (CNT_W)
    ) u_decode (
        .i_opcode  (bus.req_opcode),
        .o_strobe  (w_strobe),
        .o_lat_m1  (w_lat_m1),
        .o_branch  (w_branch),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_strobe     <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_branch     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_flag  <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.req_valid) begin
                    r_op1    <= bus.req_a;
                    r_op2    <= bus.req_b;
                    r_cnt    <= w_lat_m1;
                    r_branch <= w_branch;
                    // Illegal opcodes skip the ALU entirely and answer with an error next cycle.
                    if (w_illegal) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_data  <= '0;
                        r_resp_flag  <= 1'b0;
                    end else begin
                        r_state  <= S_EXEC;
                        r_strobe <= w_strobe;
                    end
                end
                S_EXEC: if (r_cnt == '0) begin
                    r_state      <= S_RESP;
                    r_strobe     <= '0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_data  <= r_branch ? '0 : bus.alu_result;
                    r_resp_flag  <= r_branch ? bus.alu_com_result : 1'b0;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                S_RESP: if (bus.resp_ready) begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = rst_n && (r_state == S_IDLE);
    assign bus.alu_op1    = r_op1;
    assign bus.alu_op2    = r_op2;
    assign bus.alu_add    = r_strobe[STB_ADD];
    assign bus.alu_sub    = r_strobe[STB_SUB];
    assign bus.alu_mul    = r_strobe[STB_MUL];
    assign bus.alu_div    = r_strobe[STB_DIV];
    assign bus.alu_inv    = r_strobe[STB_INV];
    assign bus.alu_abs    = r_strobe[STB_ABS];
    assign bus.alu_com    = r_strobe[STB_COM];
    assign bus.alu_blt    = r_strobe[STB_BLT];
    assign bus.alu_beq    = r_strobe[STB_BEQ];
    assign bus.alu_bgt    = r_strobe[STB_BGT];
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_flag  = r_resp_flag;
    assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed self-checking bench for fpu_op_sequencer with a behavioural ALU stand-in.
module tb_fpu_op_sequencer;
    import fpu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fpu_op_sequencer_if #(.WIDTH(32)) bus ();

    fpu_op_sequencer #(
        .WIDTH    (32),
        .LAT_FAST (1),
        .LAT_MUL  (3),
        .LAT_DIV  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU driven by the sequencer strobes.
    always_comb begin
        bus.alu_result     = '0;
        bus.alu_com_result = 1'b0;
        if (bus.alu_add) bus.alu_result = bus.alu_op1 + bus.alu_op2;
        if (bus.alu_sub) bus.alu_result = bus.alu_op1 - bus.alu_op2;
        if (bus.alu_mul) bus.alu_result = bus.alu_op1 * bus.alu_op2;
        if (bus.alu_div) bus.alu_result = (bus.alu_op2 != 0) ? bus.alu_op1 / bus.alu_op2 : 32'hFFFF_FFFF;
        if (bus.alu_inv) bus.alu_result = ~bus.alu_op1;
        if (bus.alu_abs) bus.alu_result = {1'b0, bus.alu_op1[30:0]};
        if (bus.alu_blt) bus.alu_com_result = bus.alu_op1 < bus.alu_op2;
        if (bus.alu_beq) bus.alu_com_result = bus.alu_op1 == bus.alu_op2;
        if (bus.alu_bgt) bus.alu_com_result = bus.alu_op1 > bus.alu_op2;
    end

    logic [9:0] strobes;
    assign strobes = {bus.alu_bgt, bus.alu_beq, bus.alu_blt, bus.alu_com, bus.alu_abs,
                      bus.alu_inv, bus.alu_div, bus.alu_mul, bus.alu_sub, bus.alu_add};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, EXEC for lat cycles, RESP held for hold_cycles, then retire.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [9:0] exp_stb, input logic [31:0] exp_data,
                          input logic exp_flag, input logic exp_err, input int hold_cycles);
        check("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_opcode = op;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.resp_ready = (hold_cycles == 0);
        tick();
        // Scramble request inputs: they must be ignored while busy.
        bus.req_opcode = OP_ADD;
        bus.req_a      = 32'hDEAD_BEEF;
        bus.req_b      = 32'h1234_5678;
        if (!exp_err) begin
            for (int i = 0; i < lat; i++) begin
                check("exec_strobe", strobes, exp_stb);
                check("exec_op1", bus.alu_op1, a);
                check("exec_op2", bus.alu_op2, b);
                check("exec_no_resp", bus.resp_valid, 1'b0);
                check("exec_ready", bus.req_ready, 1'b0);
                tick();
            end
        end
        check("resp_valid", bus.resp_valid, 1'b1);
        check("resp_strobe_off", strobes, 10'd0);
        check("resp_data", bus.resp_data, exp_data);
        check("resp_flag", bus.resp_flag, exp_flag);
        check("resp_err", bus.resp_err, exp_err);
        check("resp_ready_low", bus.req_ready, 1'b0);
        for (int d = 0; d < hold_cycles; d++) begin
            tick();
            check("hold_valid", bus.resp_valid, 1'b1);
            check("hold_data", bus.resp_data, exp_data);
            check("hold_ready", bus.req_ready, 1'b0);
        end
        $display("op=%0d a=%0d b=%0d data=%0d flag=%0d err=%0d", op, a, b,
                 bus.resp_data, bus.resp_flag, bus.resp_err);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        tick();
        check("retire_valid", bus.resp_valid, 1'b0);
        check("retire_ready", bus.req_ready, 1'b1);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_opcode = OP_ADD;
        bus.req_a      = 32'd1;
        bus.req_b      = 32'd2;
        bus.resp_ready = 1'b0;

        // Reset held two cycles with a request pending
        tick();
        tick();
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_strobes", strobes, 10'd0);
        check("rst_op1", bus.alu_op1, 32'd0);
        check("rst_op2", bus.alu_op2, 32'd0);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        check("rst_resp_flag", bus.resp_flag, 1'b0);
        check("rst_resp_err", bus.resp_err, 1'b0);
        rst_n         = 1'b1;
        bus.req_valid = 1'b0;
        tick();
        check("post_rst_ready", bus.req_ready, 1'b1);
        $display("reset released req_ready=%0d", bus.req_ready);

        run_op(OP_ADD, 32'd3, 32'd4, 1, 10'b00_0000_0001, 32'd7, 1'b0, 1'b0, 0);
        run_op(OP_DIV, 32'd8, 32'd2, 8, 10'b00_0000_1000, 32'd4, 1'b0, 1'b0, 0);
        run_op(OP_MUL, 32'd6, 32'd7, 3, 10'b00_0000_0100, 32'd42, 1'b0, 1'b0, 0);
        run_op(OP_BEQ, 32'd5, 32'd5, 1, 10'b01_0100_0000, 32'd0, 1'b1, 1'b0, 0);
        run_op(OP_BLT, 32'd2, 32'd5, 1, 10'b00_1100_0000, 32'd0, 1'b1, 1'b0, 0);
        run_op(OP_BGT, 32'd2, 32'd5, 1, 10'b10_0100_0000, 32'd0, 1'b0, 1'b0, 0);
        run_op(OP_INV, 32'h0F0F_0000, 32'd0, 1, 10'b00_0001_0000, 32'hF0F0_FFFF, 1'b0, 1'b0, 0);
        run_op(OP_SUB, 32'd9, 32'd4, 1, 10'b00_0000_0010, 32'd5, 1'b0, 1'b0, 5);
        run_op(4'd12, 32'd1, 32'd1, 1, 10'd0, 32'd0, 1'b0, 1'b1, 0);

        // Reset in the middle of a MUL drops the op
        bus.req_valid  = 1'b1;
        bus.req_opcode = OP_MUL;
        bus.req_a      = 32'd3;
        bus.req_b      = 32'd3;
        bus.resp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("mid_mul_strobe", strobes, 10'b00_0000_0100);
        rst_n = 1'b0;
        tick();
        check("mid_rst_strobes", strobes, 10'd0);
        check("mid_rst_resp", bus.resp_valid, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("after_rst_resp", bus.resp_valid, 1'b0);
            check("after_rst_strobes", strobes, 10'd0);
            check("after_rst_ready", bus.req_ready, 1'b1);
        end
        $display("reset during MUL: resp_valid=%0d strobes=0x%0h", bus.resp_valid, strobes);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
